// File: rtl/mux_lut_pkg.sv
// Shared codes and state encoding for the mux-based
// function sequencer and its lookup mux.
package mux_lut_pkg;

   localparam logic [1:0] CFG_ZERO = 2'b00;
   localparam logic [1:0] CFG_ONE  = 2'b01;
   localparam logic [1:0] CFG_D    = 2'b10;
   localparam logic [1:0] CFG_ND   = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_SCAN = 2'b01,
      S_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/lut_mux8.sv
// Combinational 2^NSEL:1 mux whose inputs are each
// programmed as 0, 1, d or ~d by a 2-bit code.
module lut_mux8
   import mux_lut_pkg::*;
#(
   parameter int NSEL = 3
) (
   input  logic [2*(2**NSEL)-1:0] cfg,
   input  logic [NSEL-1:0]        sel,
   input  logic                   d,
   output logic                   y
);

   logic [1:0] code;

   assign code = cfg[2*sel +: 2];

   always_comb begin
      y = 1'b0;
      unique case (code)
         CFG_ZERO: y = 1'b0;
         CFG_ONE:  y = 1'b1;
         CFG_D:    y = d;
         CFG_ND:   y = ~d;
         default:  y = 1'b0;
      endcase
   end

endmodule

// File: rtl/mux_lut_sequencer.sv
// Scans every minterm of a programmable 4-variable
// function, building its truth table and ones count.
module mux_lut_sequencer
   import mux_lut_pkg::*;
#(
   parameter int NSEL = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_wr,
   input  logic [NSEL-1:0]         cfg_addr,
   input  logic [1:0]              cfg_code,
   output logic                    cfg_err,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic [NSEL:0]           mint_idx,
   output logic [2**(NSEL+1)-1:0]  table_out,
   output logic [NSEL+1:0]         ones_cnt
);

   localparam int NIN = 2**NSEL;
   localparam logic [NSEL:0] LAST = '1;

   state_t               state;
   logic [2*NIN-1:0]     cfg;
   logic                 y;

   lut_mux8 #(
      .NSEL (NSEL)
   ) u_mux (
      .cfg (cfg),
      .sel (mint_idx[NSEL:1]),
      .d   (mint_idx[0]),
      .y   (y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cfg       <= '0;
         table_out <= '0;
         ones_cnt  <= '0;
         mint_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         // Table contents would go inconsistent mid-scan, so drop
         if (cfg_wr) begin
            if (state == S_SCAN) cfg_err <= 1'b1;
            else cfg[2*cfg_addr +: 2] <= cfg_code;
         end
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  table_out <= '0;
                  ones_cnt  <= '0;
                  mint_idx  <= '0;
                  busy      <= 1'b1;
                  state     <= S_SCAN;
               end
            end
            S_SCAN: begin
               table_out[mint_idx] <= y;
               ones_cnt <= ones_cnt + (NSEL+2)'(y);
               if (mint_idx == LAST) begin
                  busy  <= 1'b0;
                  state <= S_DONE;
               end else begin
                  mint_idx <= mint_idx + 1'b1;
               end
            end
            S_DONE: begin
               done     <= 1'b1;
               mint_idx <= '0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
